// File: rtl/decoded_instr_queue.sv
// In-order queue of decoded instructions between decode and issue, with a hold after control flow.
// Optional combinational pass-through from decode to issue on an empty queue: define DIQ_BYPASS_EN.
package decoded_instr_queue_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [7:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } scoreboard_entry_t;
endpackage

// state       | meaning
// RUN         | oldest entry is offered to issue
// WAIT_BRANCH | a control-flow instruction was issued; hold until execute resolves it
module decoded_instr_queue
    import decoded_instr_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  scoreboard_entry_t            decoded_instr_i,
    input  logic                         decoded_instr_valid_i,
    input  logic                         is_ctrl_flow_i,
    output logic                         decoded_instr_ack_o,
    output scoreboard_entry_t            issue_instr_o,
    output logic                         issue_instr_valid_o,
    output logic                         issue_is_ctrl_flow_o,
    input  logic                         issue_ack_i,
    input  logic                         resolve_branch_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic {
        RUN         = 1'b0,
        WAIT_BRANCH = 1'b1
    } state_t;

    state_t            state;
    scoreboard_entry_t instr_mem [DEPTH];
    logic [DEPTH-1:0]  ctrl_mem;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;

    logic empty;
    logic full;
    logic running;
    logic push;
    logic pop;
    logic pass;
    logic ctrl_taken;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign running = (state == RUN);
    assign count_o = count;

    // Acceptance ignores issue_ack_i so a full queue never depends on a same-cycle pop.
    assign decoded_instr_ack_o = decoded_instr_valid_i & ~full & ~flush_i & ~rst_i;
    assign pop = ~empty & running & issue_ack_i & ~flush_i & ~rst_i;

`ifdef DIQ_BYPASS_EN
    logic bypass;
    assign bypass               = empty & running & ~flush_i & ~rst_i;
    assign pass                 = bypass & decoded_instr_valid_i & issue_ack_i;
    assign issue_instr_valid_o  = bypass ? decoded_instr_valid_i : (~empty & running);
    assign issue_instr_o        = bypass ? decoded_instr_i : instr_mem[rd_ptr];
    assign issue_is_ctrl_flow_o = bypass ? (decoded_instr_valid_i & is_ctrl_flow_i)
                                         : (~empty & running & ctrl_mem[rd_ptr]);
`else
    assign pass                 = 1'b0;
    assign issue_instr_valid_o  = ~empty & running;
    assign issue_instr_o        = instr_mem[rd_ptr];
    assign issue_is_ctrl_flow_o = ~empty & running & ctrl_mem[rd_ptr];
`endif

    // A passed-through instruction is consumed directly and never occupies storage.
    assign push       = decoded_instr_ack_o & ~pass;
    assign ctrl_taken = (pop & ctrl_mem[rd_ptr]) | (pass & is_ctrl_flow_i);

    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_mem[wr_ptr] <= decoded_instr_i;
            ctrl_mem[wr_ptr]  <= is_ctrl_flow_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            state  <= RUN;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (running) begin
                if (ctrl_taken) begin
                    state <= WAIT_BRANCH;
                end
            end else if (resolve_branch_i) begin
                state <= RUN;
            end
        end
    end

endmodule

// File: tb/tb_decoded_instr_queue.sv
// Randomized and directed bench for decoded_instr_queue: queue-based reference model plus
// a scoreboard monitor that checks every instruction handed to issue.
module tb_decoded_instr_queue;
    import decoded_instr_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);
    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, flush, dvalid, is_ctrl, iack, resolve;
    scoreboard_entry_t din, iout;
    logic              ack, ivalid, ictrl;
    logic [CW-1:0]     cnt;

    decoded_instr_queue #(.DEPTH(DEPTH)) dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .flush_i               (flush),
        .decoded_instr_i       (din),
        .decoded_instr_valid_i (dvalid),
        .is_ctrl_flow_i        (is_ctrl),
        .decoded_instr_ack_o   (ack),
        .issue_instr_o         (iout),
        .issue_instr_valid_o   (ivalid),
        .issue_is_ctrl_flow_o  (ictrl),
        .issue_ack_i           (iack),
        .resolve_branch_i      (resolve),
        .count_o               (cnt)
    );

    typedef struct {
        scoreboard_entry_t data;
        logic              ctrl;
    } ent_t;

    ent_t model_q[$];
    ent_t exp_q[$];
    ent_t mon_e;
    bit   wait_br;
    bit   after_rst;
    int   checks;
    int   errors;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic scoreboard_entry_t rand_entry();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[$bits(scoreboard_entry_t)-1:0];
    endfunction

    // One clock cycle: drive inputs, check at negedge against the model, advance the model.
    task automatic step(input bit v, input bit c, input bit a, input bit r, input bit f, input bit rs);
        ent_t e;
        ent_t h;
        bit   bypass;
        bit   pass;
        bit   run;
        int   size;
        bit   exp_valid;
        bit   exp_ack;
        dvalid  = v;
        is_ctrl = c;
        iack    = a;
        resolve = r;
        flush   = f;
        rst     = rs;
        din     = rand_entry();
        @(negedge clk);
        size   = model_q.size();
        run    = !wait_br;
        bypass = 1'b0;
`ifdef DIQ_BYPASS_EN
        bypass = (size == 0) && run && !f && !rs;
`endif
        exp_valid = bypass ? v : (size > 0 && run);
        exp_ack   = v && (size < DEPTH) && !f && !rs;
        chk("count", 64'(cnt), 64'(size));
        chk("valid", 64'(ivalid), 64'(exp_valid));
        chk("ack", 64'(ack), 64'(exp_ack));
        if (after_rst && !exp_valid) chk("ctrl_after_reset", 64'(ictrl), 64'(0));
        after_rst = rs;
        if (rs || f) begin
            model_q.delete();
            exp_q.delete();
            wait_br = 1'b0;
        end else begin
            pass   = bypass && v && a;
            e.data = din;
            e.ctrl = c;
            if (exp_ack) begin
                exp_q.push_back(e);
                if (!pass) model_q.push_back(e);
            end
            if (run) begin
                if (pass && c) begin
                    wait_br = 1'b1;
                end else if (!bypass && exp_valid && a) begin
                    h = model_q.pop_front();
                    if (h.ctrl) wait_br = 1'b1;
                end
            end else if (r) begin
                wait_br = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every completed issue handshake must match the next accepted instruction.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (ivalid && iack && !flush && !rst) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL issue_unexpected actual=%0h required=none", iout);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("issue_data", 64'(iout), 64'(mon_e.data));
                    chk("issue_ctrl", 64'(ictrl), 64'(mon_e.ctrl));
                end
            end
        end
    end

    initial begin
        checks = 0; errors = 0; wait_br = 1'b0; after_rst = 1'b0;
        rst = 1'b1; flush = 1'b0; dvalid = 1'b0; is_ctrl = 1'b0; iack = 1'b0; resolve = 1'b0;
        din = '0;
        @(posedge clk);
        #1;
        step(H, L, L, L, L, H);
        step(L, L, L, L, L, L);

        // fill past full, then drain in order
        repeat (5) step(H, L, L, L, L, L);
        repeat (5) step(L, L, H, L, L, L);

        // steady push+pop at two entries, pointers wrap
        repeat (2) step(H, L, L, L, L, L);
        repeat (10) step(H, L, H, L, L, L);
        repeat (3) step(L, L, H, L, L, L);

        // branch hold and release
        step(H, H, L, L, L, L);
        step(H, L, L, L, L, L);
        step(H, L, L, L, L, L);
        step(L, L, H, L, L, L);
        repeat (3) step(L, L, H, L, L, L);
        step(L, L, L, H, L, L);
        repeat (3) step(L, L, H, L, L, L);

        // flush with three entries and a push attempt, then flush out of WAIT_BRANCH
        repeat (3) step(H, L, L, L, L, L);
        step(H, L, H, L, H, L);
        step(H, H, L, L, L, L);
        step(H, L, H, L, L, L);
        step(L, L, H, L, H, L);
        step(H, L, L, L, L, L);
        repeat (2) step(L, L, H, L, L, L);

        // reset with two entries held in WAIT_BRANCH
        step(H, H, L, L, L, L);
        step(H, L, L, L, L, L);
        step(H, L, H, L, L, L);
        step(L, L, H, L, L, L);
        step(H, L, H, L, L, H);
        step(H, L, L, L, L, L);
        repeat (2) step(L, L, H, L, L, L);

`ifdef DIQ_BYPASS_EN
        step(H, L, H, L, L, L);
        step(H, L, H, L, L, L);
        step(H, H, H, L, L, L);
        step(H, L, H, L, L, L);
        step(L, L, L, H, L, L);
        repeat (2) step(L, L, H, L, L, L);
`endif

        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 96) == 0);
        end

        repeat (DEPTH + 2) step(L, L, H, H, L, L);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
